dbus_arbiter: RTL and testbench

//  Shares the single core DBus between two requesters: M0 = LSU (load/store path), M1 = secondary master (debug/DMA).

---
 rtl/dbus_arbiter_pkg.sv | 18 +
 rtl/dbus_arb_watchdog.sv | 35 +++
 rtl/dbus_arbiter.sv | 113 +++++++++++
 tb/tb_dbus_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the two-master data-bus arbiter: bus word, request bundle, FSM states.
package dbus_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int DBUS_ARB_TIMEOUT_DEFAULT = 255;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [XLEN/8-1:0] strb_t;

  typedef enum logic [1:0] {DARB_IDLE, DARB_BUSY0, DARB_BUSY1} dbus_arb_state_t;

  typedef struct packed {
    logic  rd_en;
    logic  wr_en;
    word_t addr;
    word_t wr_data;
    strb_t wr_strobe;
  } dbus_req_t;
endpackage

// File: rtl/dbus_arb_watchdog.sv
// Counts consecutive slave-wait cycles of a locked transaction; expire_o flags the
// cycle that reaches the limit. TIMEOUT_CYCLES=0 removes the counter entirely.
module dbus_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);
      logic [TO_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign expire_o = en_i && (cnt_q == LAST);
    end else begin : g_nowd
      assign expire_o = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/dbus_arbiter.sv
// Two-master DBus arbiter: same-cycle round-robin grant in IDLE, grant locked while
// the slave stalls, watchdog abort of hung transactions.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DBUS_ARB_TIMEOUT_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  m0_rd_en,
  input  logic  m0_wr_en,
  input  word_t m0_addr,
  input  word_t m0_wr_data,
  input  strb_t m0_wr_strobe,
  output word_t m0_rd_data,
  output logic  m0_wait,
  output logic  m0_err,
  input  logic  m1_rd_en,
  input  logic  m1_wr_en,
  input  word_t m1_addr,
  input  word_t m1_wr_data,
  input  strb_t m1_wr_strobe,
  output word_t m1_rd_data,
  output logic  m1_wait,
  output logic  m1_err,
  output logic  dbus_rd_en,
  output logic  dbus_wr_en,
  output word_t dbus_addr,
  output word_t dbus_wr_data,
  output strb_t dbus_wr_strobe,
  input  word_t dbus_rd_data,
  input  logic  dbus_wait,
  input  logic  dbus_err
);
  dbus_arb_state_t  state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  dbus_req_t [1:0]  mreq;
  dbus_req_t        sel;
  logic [1:0]       req, mine;
  logic             busy, gnt, gnt_vld, drop, kill, done, wd_expire;

  assign mreq[0] = '{rd_en: m0_rd_en, wr_en: m0_wr_en, addr: m0_addr,
                     wr_data: m0_wr_data, wr_strobe: m0_wr_strobe};
  assign mreq[1] = '{rd_en: m1_rd_en, wr_en: m1_wr_en, addr: m1_addr,
                     wr_data: m1_wr_data, wr_strobe: m1_wr_strobe};
  assign req  = {m1_rd_en | m1_wr_en, m0_rd_en | m0_wr_en};
  assign busy = (state_q != DARB_IDLE);

  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    case (state_q)
      DARB_IDLE: begin
        gnt_vld = |req;
        gnt     = (&req) ? ~last_gnt_q : req[1];
      end
      DARB_BUSY0: begin gnt_vld = 1'b1; gnt = 1'b0; end
      DARB_BUSY1: begin gnt_vld = 1'b1; gnt = 1'b1; end
      default: ;
    endcase
  end

  // A locked master that lets go of its request abandons the transaction.
  assign sel  = mreq[gnt];
  assign drop = busy & ~req[gnt];
  assign kill = drop | wd_expire;
  assign done = gnt_vld & (~dbus_wait | dbus_err | kill);

  assign dbus_wr_en     = gnt_vld & ~kill & sel.wr_en;
  assign dbus_rd_en     = gnt_vld & ~kill & sel.rd_en & ~sel.wr_en;
  assign dbus_addr      = gnt_vld ? sel.addr      : '0;
  assign dbus_wr_data   = gnt_vld ? sel.wr_data   : '0;
  assign dbus_wr_strobe = gnt_vld ? sel.wr_strobe : '0;

  assign mine[0] = gnt_vld & ~gnt & req[0];
  assign mine[1] = gnt_vld &  gnt & req[1];

  assign m0_rd_data = mine[0] ? dbus_rd_data : '0;
  assign m0_wait    = mine[0] ? (dbus_wait & ~wd_expire) : req[0];
  assign m0_err     = mine[0] & (dbus_err | wd_expire);
  assign m1_rd_data = mine[1] ? dbus_rd_data : '0;
  assign m1_wait    = mine[1] ? (dbus_wait & ~wd_expire) : req[1];
  assign m1_err     = mine[1] & (dbus_err | wd_expire);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    if (done) begin
      state_d    = DARB_IDLE;
      last_gnt_d = gnt;
    end else if (!busy && gnt_vld) begin
      state_d = gnt ? DARB_BUSY1 : DARB_BUSY0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DARB_IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  dbus_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (~busy),
    .en_i     (busy & dbus_wait),
    .expire_o (wd_expire)
  );
endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed scoreboard bench for dbus_arbiter, built with a 4-cycle watchdog.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  logic  clk = 1'b0, rst_n = 1'b0;
  logic  m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
  word_t m0_addr, m0_wr_data, m1_addr, m1_wr_data;
  strb_t m0_wr_strobe, m1_wr_strobe;
  word_t m0_rd_data, m1_rd_data;
  logic  m0_wait, m0_err, m1_wait, m1_err;
  logic  dbus_rd_en, dbus_wr_en, dbus_wait, dbus_err;
  word_t dbus_addr, dbus_wr_data, dbus_rd_data;
  strb_t dbus_wr_strobe;

  always #5 clk = ~clk;

  dbus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_wr_strobe(m0_wr_strobe),
    .m0_rd_data(m0_rd_data), .m0_wait(m0_wait), .m0_err(m0_err),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_wr_strobe(m1_wr_strobe),
    .m1_rd_data(m1_rd_data), .m1_wait(m1_wait), .m1_err(m1_err),
    .dbus_rd_en(dbus_rd_en), .dbus_wr_en(dbus_wr_en), .dbus_addr(dbus_addr),
    .dbus_wr_data(dbus_wr_data), .dbus_wr_strobe(dbus_wr_strobe),
    .dbus_rd_data(dbus_rd_data), .dbus_wait(dbus_wait), .dbus_err(dbus_err)
  );

  typedef struct {
    string tag;
    logic  rd, wr;
    word_t addr, wdata;
    logic  w0, e0;
    word_t d0;
    logic  w1, e1;
    word_t d1;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic rd, input logic wr,
                            input word_t addr, input word_t wdata,
                            input logic w0, input logic e0, input word_t d0,
                            input logic w1, input logic e1, input word_t d1);
    exp_t e;
    e.tag = tag; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.w0 = w0; e.e0 = e0; e.d0 = d0; e.w1 = w1; e.e1 = e1; e.d1 = d1;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clr_in;
    m0_rd_en = 0; m0_wr_en = 0; m0_addr = '0; m0_wr_data = '0; m0_wr_strobe = '0;
    m1_rd_en = 0; m1_wr_en = 0; m1_addr = '0; m1_wr_data = '0; m1_wr_strobe = '0;
    dbus_rd_data = '0; dbus_wait = 0; dbus_err = 0;
  endtask

  task automatic rst_pulse;
    clr_in();
    rst_n = 0;
    expect_out("rst", 0,0,'0,'0, 0,0,'0, 0,0,'0);
    tick();
    rst_n = 1;
  endtask

  // Outputs are combinational: compare mid-cycle, away from the edge that moved inputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".rd_en"},  word_t'(dbus_rd_en), word_t'(e.rd));
      chk({e.tag, ".wr_en"},  word_t'(dbus_wr_en), word_t'(e.wr));
      chk({e.tag, ".addr"},   dbus_addr,           e.addr);
      chk({e.tag, ".wdata"},  dbus_wr_data,        e.wdata);
      chk({e.tag, ".m0_wait"}, word_t'(m0_wait),   word_t'(e.w0));
      chk({e.tag, ".m0_err"},  word_t'(m0_err),    word_t'(e.e0));
      chk({e.tag, ".m0_rdat"}, m0_rd_data,         e.d0);
      chk({e.tag, ".m1_wait"}, word_t'(m1_wait),   word_t'(e.w1));
      chk({e.tag, ".m1_err"},  word_t'(m1_err),    word_t'(e.e1));
      chk({e.tag, ".m1_rdat"}, m1_rd_data,         e.d1);
    end
  end

  initial begin
    clr_in();
    tick();
    rst_pulse();

    // single read, zero-latency grant
    m0_rd_en = 1; m0_addr = 32'h100; dbus_rd_data = 32'hDEADBEEF;
    expect_out("t1_rd", 1,0,32'h100,'0, 0,0,32'hDEADBEEF, 0,0,'0); tick();
    m0_rd_en = 0; m0_addr = '0;
    expect_out("t1_idle", 0,0,'0,'0, 0,0,'0, 0,0,'0); tick();

    // simultaneous writes from reset; M1 also has rd_en set (write wins)
    rst_pulse();
    m0_wr_en = 1; m0_addr = 32'h200; m0_wr_data = 32'hA0A0A0A0; m0_wr_strobe = 4'hF;
    m1_rd_en = 1; m1_wr_en = 1; m1_addr = 32'h300; m1_wr_data = 32'hB1B1B1B1; m1_wr_strobe = 4'h3;
    expect_out("t2_c0", 0,1,32'h200,32'hA0A0A0A0, 0,0,'0, 1,0,'0); tick();
    expect_out("t2_c1", 0,1,32'h300,32'hB1B1B1B1, 1,0,'0, 0,0,'0); tick();
    expect_out("t2_c2", 0,1,32'h200,32'hA0A0A0A0, 0,0,'0, 1,0,'0); tick();

    // M1 locked for a 4-cycle transaction while M0 waits
    clr_in();
    m0_rd_en = 1; m0_addr = 32'h400; m1_rd_en = 1; m1_addr = 32'h500;
    dbus_wait = 1; dbus_rd_data = 32'h11112222;
    for (int i = 0; i < 3; i++) begin
      expect_out("t3_lock", 1,0,32'h500,'0, 1,0,'0, 1,0,32'h11112222); tick();
    end
    dbus_wait = 0;
    expect_out("t3_done", 1,0,32'h500,'0, 1,0,'0, 0,0,32'h11112222); tick();
    m1_rd_en = 0;
    expect_out("t3_m0", 1,0,32'h400,'0, 0,0,32'h11112222, 0,0,'0); tick();

    // watchdog abort after four locked wait cycles, then M1 is served
    clr_in();
    m0_rd_en = 1; m0_addr = 32'h600; dbus_wait = 1;
    expect_out("t4_c0", 1,0,32'h600,'0, 1,0,'0, 0,0,'0); tick();
    m1_rd_en = 1; m1_addr = 32'h700;
    for (int i = 0; i < 3; i++) begin
      expect_out("t4_wait", 1,0,32'h600,'0, 1,0,'0, 1,0,'0); tick();
    end
    expect_out("t4_abort", 0,0,32'h600,'0, 0,1,'0, 1,0,'0); tick();
    m0_rd_en = 0; dbus_wait = 0;
    expect_out("t4_m1", 1,0,32'h700,'0, 0,0,'0, 0,0,'0); tick();

    // M0 drops its request while locked
    clr_in();
    m0_wr_en = 1; m0_addr = 32'h800; m0_wr_data = 32'hC3C3C3C3; dbus_wait = 1;
    expect_out("t5_c0", 0,1,32'h800,32'hC3C3C3C3, 1,0,'0, 0,0,'0); tick();
    expect_out("t5_c1", 0,1,32'h800,32'hC3C3C3C3, 1,0,'0, 0,0,'0); tick();
    m0_wr_en = 0;
    expect_out("t5_drop", 0,0,32'h800,32'hC3C3C3C3, 0,0,'0, 0,0,'0); tick();
    clr_in();
    m0_rd_en = 1; m0_addr = 32'h900; m1_rd_en = 1; m1_addr = 32'hA00;
    expect_out("t5_tie", 1,0,32'hA00,'0, 1,0,'0, 0,0,'0); tick();
    m1_rd_en = 0;
    expect_out("t5_m0", 1,0,32'h900,'0, 0,0,'0, 0,0,'0); tick();

    // async reset in the middle of a locked M1 transaction
    clr_in();
    m1_rd_en = 1; m1_addr = 32'hB00; dbus_wait = 1;
    expect_out("t6_c0", 1,0,32'hB00,'0, 0,0,'0, 1,0,'0); tick();
    m0_rd_en = 1; m0_addr = 32'hC00;
    expect_out("t6_c1", 1,0,32'hB00,'0, 1,0,'0, 1,0,'0); tick();
    #2;
    clr_in();
    rst_n = 0;
    #1;
    chk("t6_rst.rd_en", word_t'(dbus_rd_en), '0);
    chk("t6_rst.addr",  dbus_addr,           '0);
    chk("t6_rst.m0_wait", word_t'(m0_wait),  '0);
    chk("t6_rst.m1_wait", word_t'(m1_wait),  '0);
    #2;
    rst_n = 1;
    @(posedge clk); #1;
    m0_rd_en = 1; m0_addr = 32'hC00; m1_rd_en = 1; m1_addr = 32'hD00;
    expect_out("t6_tie", 1,0,32'hC00,'0, 0,0,'0, 1,0,'0); tick();

    // err with wait ends the transaction in the grant cycle
    m0_rd_en = 0; dbus_wait = 1; dbus_err = 1; dbus_rd_data = 32'h77;
    expect_out("t7_err", 1,0,32'hD00,'0, 0,0,'0, 1,1,32'h77); tick();
    m0_rd_en = 1; dbus_wait = 0; dbus_err = 0; dbus_rd_data = '0;
    expect_out("t7_tie", 1,0,32'hC00,'0, 0,0,'0, 1,0,'0); tick();
    clr_in();
    expect_out("end_idle", 0,0,'0,'0, 0,0,'0, 0,0,'0); tick();

    repeat (3) @(posedge clk);
    chk("sb_drain", word_t'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
